mmio_pwm_bank: RTL and testbench
================================

// Module: mmio_pwm_bank
// PURPOSE
//  Memory-mapped, parametrised PWM bank driving NUM_CH LED pins (RGB_R/G/B on the board) from the CPU's data bus.
//  Sits beside data memory in top; the core writes duty/prescale registers via store instructions, reads them back via loads.
//  Duty values are double-buffered and take effect only at a PWM period boundary, so outputs never glitch mid-period.
// PARAMETERS
//  NUM_CH     3             number of PWM channels / output pins
//  PWM_WIDTH  8             PWM counter width; period = 2**PWM_WIDTH ticks
//  BASE_ADDR  32'hFFFF_FF00 byte address of register 0; block decodes BASE_ADDR .. BASE_ADDR+4*(2+NUM_CH)-1
// PORTS
//  clk        in   1           system clock, all logic rising-edge
//  rst_n      in   1           synchronous active-low reset
//  bus_addr   in   32          byte address, word-aligned (addr[1:0] ignored)
//  bus_wdata  in   32          write data
//  bus_we     in   1           write strobe, 1-cycle pulse, full-word write
//  bus_re     in   1           read strobe, 1-cycle pulse
//  bus_rdata  out  32          read data, valid in the cycle bus_rvalid=1
//  bus_rvalid out  1           read response; high exactly one cycle after an in-range bus_re
//  pwm_out    out  NUM_CH      registered PWM outputs, bit i = channel i
//  period_end out  1           1-cycle pulse on each PWM period wrap (tick with cnt==max)
// BEHAVIOUR
//  Register map (word offsets): 0 CTRL {bit1 INVERT, bit0 EN}; 1 PRESCALE [15:0]; 2+i DUTY[i] [PWM_WIDTH:0].
//  Unused bits write-ignored, read 0. Writes outside the decoded range are ignored; reads outside give no rvalid.
//  Reset: CTRL=0, PRESCALE=0, all DUTY=0, all shadow duty=0, prescaler=0, pwm cnt=0, pwm_out=0,
//   bus_rdata=0, bus_rvalid=0, period_end=0. Reset mid-period takes effect next edge, no residual pulse.
//  Prescaler: pre_cnt counts 0..PRESCALE; tick=1 when pre_cnt==PRESCALE, then pre_cnt<=0. PRESCALE=0 -> tick every cycle.
//  PWM counter: cnt (PWM_WIDTH bits) increments on tick, wraps 2**PWM_WIDTH-1 -> 0 (natural overflow).
//  period_end = EN & tick & (cnt == all-ones); registered, so it asserts the cycle after that condition.
//  Shadow load: on period-end condition, shadow[i] <= DUTY[i] (the value held BEFORE any same-cycle write);
//   a DUTY write coincident with period end lands in DUTY and applies at the following boundary.
//  Compare: raw[i] = (cnt < shadow[i]); shadow is PWM_WIDTH+1 bits: 0 -> always low, 2**PWM_WIDTH -> always high,
//   values > 2**PWM_WIDTH behave as always high.
//  pwm_out[i] <= EN ? (raw[i] ^ INVERT) : INVERT; one-cycle latency from cnt to pin.
//  While EN=0: pre_cnt and cnt held at 0, shadow[i] continuously tracks DUTY[i], no period_end.
//   EN 0->1: first tick occurs PRESCALE+1 cycles after the write; new duty active immediately from cnt=0.
//  PRESCALE write mid-count: new compare value used immediately; if pre_cnt > new PRESCALE,
//   pre_cnt continues to 16-bit wrap (documented, not corrected).
//  Reads: bus_rdata/bus_rvalid registered, one-cycle latency; returns architectural regs (not shadows).
//   bus_we and bus_re same cycle same address: write applies; read returns the OLD value.
// STRUCTURE
//  pwm_pkg: register word offsets (REG_CTRL, REG_PRESCALE, REG_DUTY0), CTRL bit indices, PRESCALE_W=16.
//  Sub-module pwm_timebase: prescaler + cnt + tick/period_end generation; parent holds regs, shadows, compare.
//  Channels generated with a for-generate over NUM_CH; no multipliers, no latches.
// TESTING
//  1 Reset: hold rst_n=0 4 cycles with bus_we pulses -> all outputs 0, reads of CTRL/DUTY0 return 0.
//  2 NUM_CH=3, W=8, PRESCALE=0, DUTY0=64, DUTY1=0, DUTY2=256, EN=1 -> per 256-cycle period ch0 high 64 cycles,
//    ch1 never high, ch2 always high; period_end every 256 cycles.
//  3 PRESCALE=3, DUTY0=128 -> ch0 high 512 of 1024 cycles; period_end spacing 1024 cycles.
//  4 Write DUTY0=32 mid-period (cnt=100, old 128) -> current period finishes at 128 duty; next period 32.
//  5 INVERT=1, EN=1, DUTY0=64 -> ch0 low 64, high 192 per period; EN=0 -> all pins =1 (idle = INVERT).
//  6 Same-cycle we+re to DUTY1 (old 10, new 20) -> rdata=10 next cycle; re at BASE+0x40 -> no rvalid.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared register map, control-word layout and widths for the memory-mapped PWM bank.
package pwm_pkg;

   localparam int unsigned REG_CTRL     = 0;
   localparam int unsigned REG_PRESCALE = 1;
   localparam int unsigned REG_DUTY0    = 2;

   localparam int unsigned CTRL_EN_BIT  = 0;
   localparam int unsigned CTRL_INV_BIT = 1;

   localparam int unsigned PRESCALE_W   = 16;

   typedef struct packed {
      logic invert;
      logic en;
   } ctrl_t;

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler and shared PWM counter; flags the period-end tick used to reload duty shadows.
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int unsigned PWM_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [PWM_WIDTH-1:0]  cnt,
   output logic                  load,
   output logic                  period_end
);

   logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [PWM_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  period_end_q, period_end_d;
   logic                  tick;

   // A prescale lowered below pre_cnt is not caught here: pre_cnt runs on to its 16-bit wrap.
   always_comb begin
      tick         = en && (pre_cnt_q == prescale);
      load         = tick && (cnt_q == '1);
      pre_cnt_d    = pre_cnt_q + PRESCALE_W'(1);
      cnt_d        = cnt_q;
      period_end_d = load;
      if (!en) begin
         pre_cnt_d = '0;
         cnt_d     = '0;
      end else if (tick) begin
         pre_cnt_d = '0;
         cnt_d     = cnt_q + PWM_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_cnt_q    <= '0;
         cnt_q        <= '0;
         period_end_q <= 1'b0;
      end else begin
         pre_cnt_q    <= pre_cnt_d;
         cnt_q        <= cnt_d;
         period_end_q <= period_end_d;
      end
   end

   assign cnt        = cnt_q;
   assign period_end = period_end_q;

endmodule

// File: rtl/mmio_pwm_bank.sv
// Memory-mapped PWM bank: CTRL/PRESCALE/DUTY registers on the CPU data bus, double-buffered duty per channel.
module mmio_pwm_bank
   import pwm_pkg::*;
#(
   parameter int unsigned NUM_CH    = 3,
   parameter int unsigned PWM_WIDTH = 8,
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       bus_addr,
   input  logic [31:0]       bus_wdata,
   input  logic              bus_we,
   input  logic              bus_re,
   output logic [31:0]       bus_rdata,
   output logic              bus_rvalid,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              period_end
);

   localparam logic [31:0] NUM_REGS = 32'(REG_DUTY0 + NUM_CH);

   logic [31:0]                    word;
   logic                           wr_hit, rd_hit;
   ctrl_t                          ctrl_q, ctrl_d;
   logic [PRESCALE_W-1:0]          prescale_q, prescale_d;
   logic [31:0]                    rdata_q, rdata_d;
   logic                           rvalid_q, rvalid_d;
   logic [NUM_CH-1:0][PWM_WIDTH:0] duty_all;
   logic [NUM_CH-1:0]              pwm_all;
   logic [PWM_WIDTH-1:0]           cnt;
   logic                           load;
   logic                           unused_bits;

   // Word offset from base; addresses below base wrap to huge values and fall out of range.
   assign word   = {2'b00, bus_addr[31:2] - BASE_ADDR[31:2]};
   assign wr_hit = bus_we && (word < NUM_REGS);
   assign rd_hit = bus_re && (word < NUM_REGS);
   assign unused_bits = &{1'b0, bus_wdata[31:PRESCALE_W], bus_addr[1:0]};

   always_comb begin
      ctrl_d     = ctrl_q;
      prescale_d = prescale_q;
      if (wr_hit && (word == REG_CTRL))
         ctrl_d = ctrl_t'(bus_wdata[CTRL_INV_BIT:CTRL_EN_BIT]);
      if (wr_hit && (word == REG_PRESCALE))
         prescale_d = bus_wdata[PRESCALE_W-1:0];

      rvalid_d = rd_hit;
      rdata_d  = '0;
      if (rd_hit) begin
         if (word == REG_CTRL)
            rdata_d = 32'(ctrl_q);
         if (word == REG_PRESCALE)
            rdata_d = 32'(prescale_q);
         for (int unsigned i = 0; i < NUM_CH; i++)
            if (word == REG_DUTY0 + i)
               rdata_d = 32'(duty_all[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctrl_q     <= '0;
         prescale_q <= '0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
      end else begin
         ctrl_q     <= ctrl_d;
         prescale_q <= prescale_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
      end
   end

   pwm_timebase #(
      .PWM_WIDTH(PWM_WIDTH)
   ) u_timebase (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (ctrl_q.en),
      .prescale  (prescale_q),
      .cnt       (cnt),
      .load      (load),
      .period_end(period_end)
   );

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [31:0] DUTY_WORD = 32'(REG_DUTY0 + i);

      logic [PWM_WIDTH:0] duty_q, duty_d;
      logic [PWM_WIDTH:0] shadow_q, shadow_d;
      logic               pwm_q, pwm_d;
      logic               raw;

      // Shadow samples the pre-write duty, so a same-cycle write waits for the next boundary.
      always_comb begin
         duty_d = duty_q;
         if (wr_hit && (word == DUTY_WORD))
            duty_d = bus_wdata[PWM_WIDTH:0];
         shadow_d = shadow_q;
         if (!ctrl_q.en || load)
            shadow_d = duty_q;
         raw   = ({1'b0, cnt} < shadow_q);
         pwm_d = ctrl_q.en ? (raw ^ ctrl_q.invert) : ctrl_q.invert;
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            duty_q   <= '0;
            shadow_q <= '0;
            pwm_q    <= 1'b0;
         end else begin
            duty_q   <= duty_d;
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
         end
      end

      assign duty_all[i] = duty_q;
      assign pwm_all[i]  = pwm_q;
   end

   assign pwm_out    = pwm_all;
   assign bus_rdata  = rdata_q;
   assign bus_rvalid = rvalid_q;

endmodule

// File: tb/tb_mmio_pwm_bank.sv
// Directed self-checking bench for mmio_pwm_bank (3 channels, 8-bit PWM).
module tb_mmio_pwm_bank;

   localparam logic [31:0] BASE = 32'hFFFF_FF00;
   localparam logic [31:0] O_CTRL = 32'h00;
   localparam logic [31:0] O_PRE  = 32'h04;
   localparam logic [31:0] O_D0   = 32'h08;
   localparam logic [31:0] O_D1   = 32'h0C;
   localparam logic [31:0] O_D2   = 32'h10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic        bus_we, bus_re, bus_rvalid;
   logic [2:0]  pwm_out;
   logic        period_end;

   int compared = 0;
   int mismatched = 0;
   int hi [3];
   int pe_cnt, pe_pos;
   logic [31:0] rdat;
   logic        rv;

   mmio_pwm_bank #(
      .NUM_CH   (3),
      .PWM_WIDTH(8),
      .BASE_ADDR(BASE)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_we    (bus_we),
      .bus_re    (bus_re),
      .bus_rdata (bus_rdata),
      .bus_rvalid(bus_rvalid),
      .pwm_out   (pwm_out),
      .period_end(period_end)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      compared++;
      assert (obs === exp_v)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] data);
      @(negedge clk);
      bus_addr  = BASE + off;
      bus_wdata = data;
      bus_we    = 1'b1;
      @(negedge clk);
      bus_we    = 1'b0;
   endtask

   task automatic rd(input logic [31:0] off, output logic [31:0] data, output logic valid);
      @(negedge clk);
      bus_addr = BASE + off;
      bus_re   = 1'b1;
      @(negedge clk);
      bus_re   = 1'b0;
      data     = bus_rdata;
      valid    = bus_rvalid;
   endtask

   // Samples n negedges; optionally pulses one write after sample wr_at.
   task automatic measure(input int n, input int wr_at, input logic [31:0] off, input logic [31:0] data);
      hi     = '{0, 0, 0};
      pe_cnt = 0;
      pe_pos = -1;
      for (int j = 1; j <= n; j++) begin
         @(negedge clk);
         for (int c = 0; c < 3; c++)
            if (pwm_out[c] === 1'b1) hi[c]++;
         if (period_end === 1'b1) begin
            pe_cnt++;
            pe_pos = j;
         end
         if (j == wr_at) begin
            bus_addr  = BASE + off;
            bus_wdata = data;
            bus_we    = 1'b1;
         end else begin
            bus_we = 1'b0;
         end
      end
      bus_we = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      bus_addr  = BASE;
      bus_wdata = '0;
      bus_we    = 1'b0;
      bus_re    = 1'b0;

      // 1: reset with write pulses ignored
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus_addr  = BASE + ((k % 2 == 0) ? O_CTRL : O_D0);
         bus_wdata = 32'h0000_0003;
         bus_we    = 1'b1;
      end
      @(negedge clk);
      bus_we = 1'b0;
      check("rst_pwm", 32'(pwm_out), 32'h0);
      check("rst_pe", 32'(period_end), 32'h0);
      check("rst_rvalid", 32'(bus_rvalid), 32'h0);
      check("rst_rdata", bus_rdata, 32'h0);
      rst_n = 1'b1;
      rd(O_CTRL, rdat, rv);
      check("rst_ctrl_rv", 32'(rv), 32'h1);
      check("rst_ctrl", rdat, 32'h0);
      rd(O_D0, rdat, rv);
      check("rst_duty0", rdat, 32'h0);

      // 2: prescale 0, duties 64/0/256
      wr(O_PRE, 32'd0);
      wr(O_D0, 32'd64);
      wr(O_D1, 32'd0);
      wr(O_D2, 32'd256);
      measure(8, 0, 0, 0);
      check("dis_pins", 32'(hi[0] + hi[1] + hi[2]), 32'd0);
      check("dis_pe", 32'(pe_cnt), 32'd0);
      wr(O_CTRL, 32'd1);
      measure(256, 0, 0, 0);
      check("t2_ch0", 32'(hi[0]), 32'd64);
      check("t2_ch1", 32'(hi[1]), 32'd0);
      check("t2_ch2", 32'(hi[2]), 32'd256);
      check("t2_pe_pos", 32'(pe_pos), 32'd256);
      measure(256, 0, 0, 0);
      check("t2b_ch0", 32'(hi[0]), 32'd64);
      check("t2b_pe_cnt", 32'(pe_cnt), 32'd1);
      check("t2b_pe_pos", 32'(pe_pos), 32'd256);

      // 3: prescale 3, duty0 128; first period_end 1024 cycles after enable
      wr(O_CTRL, 32'd0);
      wr(O_PRE, 32'd3);
      wr(O_D0, 32'd128);
      wr(O_CTRL, 32'd1);
      measure(1024, 0, 0, 0);
      check("t3_ch0", 32'(hi[0]), 32'd512);
      check("t3_ch2", 32'(hi[2]), 32'd1024);
      check("t3_pe_cnt", 32'(pe_cnt), 32'd1);
      check("t3_pe_pos", 32'(pe_pos), 32'd1024);

      // 4: duty0 -> 32 written around cnt=100; current period keeps 128
      measure(1024, 401, O_D0, 32'd32);
      check("t4_cur_ch0", 32'(hi[0]), 32'd512);
      check("t4_cur_pe", 32'(pe_pos), 32'd1024);
      measure(1024, 0, 0, 0);
      check("t4_next_ch0", 32'(hi[0]), 32'd128);
      check("t4_next_pe", 32'(pe_pos), 32'd1024);
      rd(O_D0, rdat, rv);
      check("t4_duty0_rd", rdat, 32'd32);

      // 5: invert
      wr(O_CTRL, 32'd0);
      wr(O_PRE, 32'd0);
      wr(O_D0, 32'd64);
      wr(O_CTRL, 32'd3);
      measure(256, 0, 0, 0);
      check("t5_ch0", 32'(hi[0]), 32'd192);
      check("t5_ch1", 32'(hi[1]), 32'd256);
      check("t5_ch2", 32'(hi[2]), 32'd0);
      check("t5_pe_pos", 32'(pe_pos), 32'd256);
      wr(O_CTRL, 32'd2);
      measure(8, 0, 0, 0);
      check("t5_idle_ch0", 32'(hi[0]), 32'd8);
      check("t5_idle_ch2", 32'(hi[2]), 32'd8);
      check("t5_idle_pe", 32'(pe_cnt), 32'd0);

      // 6: bus corner cases
      wr(O_CTRL, 32'd0);
      wr(O_D1, 32'd10);
      @(negedge clk);
      bus_addr  = BASE + O_D1;
      bus_wdata = 32'd20;
      bus_we    = 1'b1;
      bus_re    = 1'b1;
      @(negedge clk);
      bus_we = 1'b0;
      bus_re = 1'b0;
      check("t6_wr_rd_rv", 32'(bus_rvalid), 32'h1);
      check("t6_wr_rd_old", bus_rdata, 32'd10);
      @(negedge clk);
      check("t6_rv_pulse", 32'(bus_rvalid), 32'h0);
      rd(O_D1, rdat, rv);
      check("t6_duty1_new", rdat, 32'd20);
      rd(32'h40, rdat, rv);
      check("t6_oor_rv40", 32'(rv), 32'h0);
      rd(32'h14, rdat, rv);
      check("t6_oor_rv14", 32'(rv), 32'h0);
      wr(32'h14, 32'h55);
      wr(32'hFFFF_FFFC, 32'h77);
      rd(O_D2, rdat, rv);
      check("t6_duty2_kept", rdat, 32'h100);
      rd(O_CTRL, rdat, rv);
      check("t6_ctrl_kept", rdat, 32'h0);
      wr(O_D0, 32'hFFFF_FFFF);
      rd(O_D0, rdat, rv);
      check("t6_duty0_mask", rdat, 32'h1FF);
      wr(O_PRE, 32'hABCD_1234);
      rd(O_PRE, rdat, rv);
      check("t6_pre_mask", rdat, 32'h1234);
      wr(O_CTRL, 32'hFFFF_FFF0);
      rd(O_CTRL, rdat, rv);
      check("t6_ctrl_mask", rdat, 32'h0);

      // 7: reset mid-period
      wr(O_PRE, 32'd0);
      wr(O_CTRL, 32'd1);
      measure(10, 0, 0, 0);
      check("t7_ch0_high", 32'(hi[0]), 32'd10);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("t7_rst_pwm", 32'(pwm_out), 32'h0);
      check("t7_rst_pe", 32'(period_end), 32'h0);
      rst_n = 1'b1;
      measure(4, 0, 0, 0);
      check("t7_after_pins", 32'(hi[0] + hi[1] + hi[2]), 32'd0);
      rd(O_D0, rdat, rv);
      check("t7_duty0_rst", rdat, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
